dram_axi_bridge: RTL and testbench
==================================

Name: dram_axi_bridge

Overview:
Data-side bridge between the memory-stage SRAM-like port (mem_addr / mem_wdata / mem_wr / mem_ben, plus mem_addr_ok / mem_data_ok / mem_rdata) and a single-beat AXI3 master.
It sits directly downstream of the core's data-memory port and upstream of the AXI crossbar.
It handles one outstanding transaction at a time.
The top-level wrapper ties the constant AXI fields: id=1, len=0, burst=INCR, lock/cache/prot=0, wlast=1.

Parameters:
none

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mem_addr  in  32  physical byte address, held stable until mem_data_ok
mem_wdata  in  32  store data
mem_wr  in  1  1=write, 0=read
mem_ben  in  4  byte enables; nonzero = request present
mem_addr_ok  out  1  one-cycle pulse: address phase accepted
mem_data_ok  out  1  one-cycle pulse: read data valid / write acknowledged
mem_rdata  out  32  read data, registered
araddr  out  32  read address
arsize  out  3  read size
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awsize  out  3  write size
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Clock and reset: clk, rst; reset is synchronous and active-high.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE.
- Reset values: state=IDLE. All valid/ready outputs, mem_addr_ok and mem_data_ok are 0. mem_rdata=0. Address, size and data registers are 0.
- IDLE: when mem_ben!=0, register mem_addr, mem_wdata, mem_ben and the computed size. Go to WR_ADDR if mem_wr=1, else RD_ADDR.
- Size from ben: 1111->2; 0011 or 1100->1; one-hot->0; any other pattern->2 (illegal, not trapped).
- araddr/awaddr are the registered address, unmodified. wstrb is the registered ben.
- RD_ADDR: arvalid=1. On arready, pulse mem_addr_ok, drop arvalid, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, register rdata into mem_rdata, pulse mem_data_ok the following cycle, go to DONE.
- WR_ADDR: awvalid=1 and wvalid=1, each dropped independently when its own ready is seen.
  - awready and wready may arrive in the same cycle or in any order.
  - When both handshakes have completed, pulse mem_addr_ok and go to WR_RESP.
- WR_RESP: bready=1. On bvalid, pulse mem_data_ok, go to DONE.
- DONE: one bubble cycle so the core can retire the request; then IDLE. A held request is never re-issued.
- Latency with zero-wait slave: read request at cycle 0 gives arvalid at cycle 1; with rvalid at cycle 2, mem_data_ok is at cycle 3. Write: awvalid/wvalid at cycle 1, bvalid at cycle 2, mem_data_ok at cycle 2.
- rresp/bresp are not ported and are ignored. rvalid and bvalid outside RD_DATA/WR_RESP are ignored, with rready/bready held at 0.
- Valid stability: once asserted, a valid stays high with stable payload until its handshake completes.
- Reset mid-operation: returns to IDLE next cycle, all valids drop, no mem_data_ok is generated.
- mem_rdata holds its last value between reads.

Decomposition:
- Shared package: state enum, AXI size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2), data id constant 4'd1.
- Sub-module: ben_to_size (combinational ben->size), reusable by the instruction-side bridge.

Test Plan:
- Word read: mem_addr=0x1000_0040, ben=1111, wr=0; arready=1 immediately; rvalid with 0xDEADBEEF two cycles later.
  -> araddr=0x10000040, arsize=2; one mem_addr_ok pulse; mem_rdata=0xDEADBEEF with a single mem_data_ok pulse.
- Byte write: addr=0x0000_0003, ben=1000, wdata=0xAB000000; awready at cycle 1, wready at cycle 3, bvalid at cycle 5.
  -> awsize=0, wstrb=1000; awvalid drops after cycle 1, wvalid after cycle 3; mem_addr_ok at cycle 3; mem_data_ok at cycle 5.
- Write with wready before awready, and both in the same cycle.
  -> in both cases a single mem_addr_ok, and no duplicate aw or w beat.
- Back-to-back: core holds ben=1111 across mem_data_ok, then changes the request.
  -> exactly one AXI transaction per request; the DONE bubble is observed.
- Halfword read with ben=1100 while arready is stalled 5 cycles.
  -> arsize=1; arvalid and araddr stable throughout the stall.
- Assert rst during RD_DATA with rvalid pending.
  -> all outputs are at reset values next cycle, no mem_data_ok, and a new request is accepted afterwards.

Source files
------------

// File: rtl/dram_axi_bridge_pkg.sv
// Shared types and constants for the data-side SRAM-like to AXI3 bridge.
package dram_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_RESP = 3'd4,
      DONE    = 3'd5
   } state_e;

   localparam logic [2:0] SZ_BYTE    = 3'd0;
   localparam logic [2:0] SZ_HALF    = 3'd1;
   localparam logic [2:0] SZ_WORD    = 3'd2;
   localparam logic [3:0] DATA_ID    = 4'd1;
   localparam logic [1:0] BURST_INCR = 2'b01;

endpackage

// File: rtl/dram_axi_bridge_if.sv
// Memory-stage SRAM-like port plus single-beat AXI3 master channels.
interface dram_axi_bridge_if;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic [3:0]  mem_ben;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic        bvalid;
   logic        bready;

   modport master (
      input  mem_addr, mem_wdata, mem_wr, mem_ben,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rdata, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bvalid,
      output bready
   );

   modport slave (
      output mem_addr, mem_wdata, mem_wr, mem_ben,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rdata, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bvalid,
      input  bready
   );

endinterface

// File: rtl/dram_axi_bridge_ben_to_size.sv
// Byte-enable pattern to AXI transfer size; shared with the instruction-side bridge.
module dram_axi_bridge_ben_to_size
   import dram_axi_bridge_pkg::*;
(
   input  logic [3:0] ben,
   output logic [2:0] size
);

   // Illegal byte-enable patterns fall back to a full-word access
   always_comb begin
      size = SZ_WORD;
      case (ben)
         4'b1111:                            size = SZ_WORD;
         4'b0011, 4'b1100:                   size = SZ_HALF;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
         default:                            size = SZ_WORD;
      endcase
   end

endmodule

// File: rtl/dram_axi_bridge.sv
// Data-side SRAM-like to single-beat AXI3 bridge with one transaction in flight.
module dram_axi_bridge
   import dram_axi_bridge_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   dram_axi_bridge_if.master bus
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  ben_q, ben_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rd_ok_q, rd_ok_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [2:0]  req_size_s;
   logic        arvalid_s, awvalid_s, wvalid_s;
   logic        aw_hs_s, w_hs_s;
   logic        addr_ok_s, wr_ok_s;

   dram_axi_bridge_ben_to_size u_ben_to_size (
      .ben  (bus.mem_ben),
      .size (req_size_s)
   );

   // AW and W are tracked separately so each valid drops on its own handshake
   assign arvalid_s = (state_q == RD_ADDR);
   assign awvalid_s = (state_q == WR_ADDR) && !aw_done_q;
   assign wvalid_s  = (state_q == WR_ADDR) && !w_done_q;
   assign aw_hs_s   = awvalid_s && bus.awready;
   assign w_hs_s    = wvalid_s && bus.wready;

   // Next-state, request capture and handshake bookkeeping
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ben_d     = ben_q;
      size_d    = size_q;
      rdata_d   = rdata_q;
      rd_ok_d   = 1'b0;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      addr_ok_s = 1'b0;
      wr_ok_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.mem_ben != 4'b0000) begin
               addr_d    = bus.mem_addr;
               wdata_d   = bus.mem_wdata;
               ben_d     = bus.mem_ben;
               size_d    = req_size_s;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = bus.mem_wr ? WR_ADDR : RD_ADDR;
            end else begin
               state_d = IDLE;
            end
         end
         RD_ADDR: begin
            if (bus.arready) begin
               addr_ok_s = 1'b1;
               state_d   = RD_DATA;
            end else begin
               state_d = RD_ADDR;
            end
         end
         RD_DATA: begin
            if (bus.rvalid) begin
               rdata_d = bus.rdata;
               rd_ok_d = 1'b1;
               state_d = DONE;
            end else begin
               state_d = RD_DATA;
            end
         end
         WR_ADDR: begin
            if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
               addr_ok_s = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end else begin
               aw_done_d = aw_done_q || aw_hs_s;
               w_done_d  = w_done_q || w_hs_s;
               state_d   = WR_ADDR;
            end
         end
         WR_RESP: begin
            if (bus.bvalid) begin
               wr_ok_s = 1'b1;
               state_d = DONE;
            end else begin
               state_d = WR_RESP;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= 32'h0000_0000;
         wdata_q   <= 32'h0000_0000;
         ben_q     <= 4'b0000;
         size_q    <= 3'd0;
         rdata_q   <= 32'h0000_0000;
         rd_ok_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ben_q     <= ben_d;
         size_q    <= size_d;
         rdata_q   <= rdata_d;
         rd_ok_q   <= rd_ok_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign bus.mem_addr_ok = addr_ok_s;
   assign bus.mem_data_ok = rd_ok_q || wr_ok_s;
   assign bus.mem_rdata   = rdata_q;

   assign bus.arid    = DATA_ID;
   assign bus.araddr  = addr_q;
   assign bus.arlen   = 4'd0;
   assign bus.arsize  = size_q;
   assign bus.arburst = BURST_INCR;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'd0;
   assign bus.arprot  = 3'd0;
   assign bus.arvalid = arvalid_s;
   assign bus.rready  = (state_q == RD_DATA);

   assign bus.awid    = DATA_ID;
   assign bus.awaddr  = addr_q;
   assign bus.awlen   = 4'd0;
   assign bus.awsize  = size_q;
   assign bus.awburst = BURST_INCR;
   assign bus.awlock  = 2'b00;
   assign bus.awcache = 4'd0;
   assign bus.awprot  = 3'd0;
   assign bus.awvalid = awvalid_s;

   assign bus.wid     = DATA_ID;
   assign bus.wdata   = wdata_q;
   assign bus.wstrb   = ben_q;
   assign bus.wlast   = 1'b1;
   assign bus.wvalid  = wvalid_s;
   assign bus.bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_dram_axi_bridge.sv
// Directed self-checking bench for dram_axi_bridge.
module tb_dram_axi_bridge;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   ar_n = 0, aw_n = 0, w_n = 0, aok_n = 0, dok_n = 0;

   dram_axi_bridge_if bus ();

   dram_axi_bridge dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Handshake and pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.arvalid && bus.arready) ar_n++;
         if (bus.awvalid && bus.awready) aw_n++;
         if (bus.wvalid && bus.wready)   w_n++;
         if (bus.mem_addr_ok)            aok_n++;
         if (bus.mem_data_ok)            dok_n++;
      end
   end

   // {arvalid, rready, awvalid, wvalid, bready, mem_addr_ok, mem_data_ok}
   function automatic logic [6:0] ctl_vec();
      return {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
              bus.mem_addr_ok, bus.mem_data_ok};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_wr    = 1'b0;
      bus.mem_ben   = 4'b0000;
      bus.arready   = 1'b0;
      bus.rdata     = 32'h0;
      bus.rvalid    = 1'b0;
      bus.awready   = 1'b0;
      bus.wready    = 1'b0;
      bus.bvalid    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      tick(); tick(); sample();
      checks++;
      if (ctl_vec() !== 7'b0000000) begin
         errors++; $display("FAIL reset_ctl: got %b expected %b", ctl_vec(), 7'b0000000);
      end
      checks++;
      if ({bus.araddr, bus.awaddr, bus.wdata, bus.mem_rdata} !== 128'h0) begin
         errors++; $display("FAIL reset_data: got %h %h %h %h expected all 0",
                            bus.araddr, bus.awaddr, bus.wdata, bus.mem_rdata);
      end
      checks++;
      if ({bus.arsize, bus.awsize, bus.wstrb} !== 10'h000) begin
         errors++; $display("FAIL reset_size: got %h %h %h expected 0 0 0",
                            bus.arsize, bus.awsize, bus.wstrb);
      end
      checks++;
      if ({bus.arid, bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot}
          !== {4'd1, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
         errors++; $display("FAIL ar_tieoff: got id=%h len=%h burst=%b expected 1 0 01",
                            bus.arid, bus.arlen, bus.arburst);
      end
      checks++;
      if ({bus.awid, bus.awlen, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.wid, bus.wlast}
          !== {4'd1, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1, 1'b1}) begin
         errors++; $display("FAIL aw_tieoff: got id=%h len=%h burst=%b wid=%h wlast=%b expected 1 0 01 1 1",
                            bus.awid, bus.awlen, bus.awburst, bus.wid, bus.wlast);
      end
      tick();
      rst = 1'b0;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0000000) begin
         errors++; $display("FAIL post_reset_idle: got %b expected %b", ctl_vec(), 7'b0000000);
      end
   endtask

   task automatic test_word_read();
      int ar0 = ar_n, aok0 = aok_n, dok0 = dok_n;
      tick();
      bus.mem_addr = 32'h1000_0040; bus.mem_ben = 4'b1111; bus.mem_wr = 1'b0; bus.arready = 1'b1;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0000000) begin
         errors++; $display("FAIL rd_c0: got %b expected %b", ctl_vec(), 7'b0000000);
      end
      tick(); sample();
      checks++;
      if (ctl_vec() !== 7'b1000010) begin
         errors++; $display("FAIL rd_c1: got %b expected %b", ctl_vec(), 7'b1000010);
      end
      checks++;
      if (bus.araddr !== 32'h1000_0040 || bus.arsize !== 3'd2) begin
         errors++; $display("FAIL rd_addr: got %h/%0d expected 10000040/2", bus.araddr, bus.arsize);
      end
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0100000) begin
         errors++; $display("FAIL rd_c2: got %b expected %b", ctl_vec(), 7'b0100000);
      end
      tick();
      bus.rvalid = 1'b0; bus.rdata = 32'h0;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0000001 || bus.mem_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rd_c3: got %b/%h expected %b/deadbeef",
                            ctl_vec(), bus.mem_rdata, 7'b0000001);
      end
      tick();
      bus.mem_ben = 4'b0000;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0000000) begin
         errors++; $display("FAIL rd_c4: got %b expected %b", ctl_vec(), 7'b0000000);
      end
      tick(); sample();
      checks++;
      if (ar_n - ar0 != 1 || aok_n - aok0 != 1 || dok_n - dok0 != 1 || bus.mem_rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rd_counts: got ar=%0d aok=%0d dok=%0d rdata=%h expected 1 1 1 deadbeef",
                            ar_n - ar0, aok_n - aok0, dok_n - dok0, bus.mem_rdata);
      end
   endtask

   task automatic test_byte_write();
      logic [6:0] exp_ctl [8] = '{7'b0000000, 7'b0011000, 7'b0001000, 7'b0001010,
                                  7'b0000100, 7'b0000101, 7'b0000000, 7'b0000000};
      int aw0 = aw_n, w0 = w_n;
      for (int c = 0; c < 8; c++) begin
         tick();
         bus.awready = (c == 1);
         bus.wready  = (c == 3);
         bus.bvalid  = (c == 5);
         if (c == 0) begin
            bus.mem_addr = 32'h0000_0003; bus.mem_ben = 4'b1000;
            bus.mem_wdata = 32'hAB00_0000; bus.mem_wr = 1'b1;
         end
         if (c == 6) bus.mem_ben = 4'b0000;
         sample();
         checks++;
         if (ctl_vec() !== exp_ctl[c]) begin
            errors++; $display("FAIL bwr_c%0d: got %b expected %b", c, ctl_vec(), exp_ctl[c]);
         end
         if (c == 1) begin
            checks++;
            if (bus.awsize !== 3'd0 || bus.wstrb !== 4'b1000 || bus.awaddr !== 32'h3 || bus.wdata !== 32'hAB00_0000) begin
               errors++; $display("FAIL bwr_payload: got %0d %b %h %h expected 0 1000 00000003 ab000000",
                                  bus.awsize, bus.wstrb, bus.awaddr, bus.wdata);
            end
         end
      end
      checks++;
      if (aw_n - aw0 != 1 || w_n - w0 != 1) begin
         errors++; $display("FAIL bwr_beats: got aw=%0d w=%0d expected 1 1", aw_n - aw0, w_n - w0);
      end
   endtask

   task automatic test_write_order();
      logic [6:0] exp_a [5] = '{7'b0000000, 7'b0011000, 7'b0010010, 7'b0000101, 7'b0000000};
      logic [6:0] exp_b [5] = '{7'b0000000, 7'b0011010, 7'b0000101, 7'b0000000, 7'b0000000};
      int aw0 = aw_n, w0 = w_n, aok0 = aok_n;
      // Case A: wready first, awready one cycle later
      for (int c = 0; c < 5; c++) begin
         tick();
         bus.wready  = (c == 1);
         bus.awready = (c == 2);
         bus.bvalid  = (c == 3);
         if (c == 0) begin
            bus.mem_addr = 32'h0000_0100; bus.mem_ben = 4'b1111;
            bus.mem_wdata = 32'h0102_0304; bus.mem_wr = 1'b1;
         end
         if (c == 4) bus.mem_ben = 4'b0000;
         sample();
         checks++;
         if (ctl_vec() !== exp_a[c]) begin
            errors++; $display("FAIL wfirst_c%0d: got %b expected %b", c, ctl_vec(), exp_a[c]);
         end
      end
      // Case B: both readies together, zero-wait response
      for (int c = 0; c < 5; c++) begin
         tick();
         bus.wready  = (c == 1);
         bus.awready = (c == 1);
         bus.bvalid  = (c == 2);
         if (c == 0) begin
            bus.mem_addr = 32'h0000_0104; bus.mem_ben = 4'b1111;
            bus.mem_wdata = 32'h0506_0708; bus.mem_wr = 1'b1;
         end
         if (c == 3) bus.mem_ben = 4'b0000;
         sample();
         checks++;
         if (ctl_vec() !== exp_b[c]) begin
            errors++; $display("FAIL wboth_c%0d: got %b expected %b", c, ctl_vec(), exp_b[c]);
         end
      end
      checks++;
      if (aw_n - aw0 != 2 || w_n - w0 != 2 || aok_n - aok0 != 2) begin
         errors++; $display("FAIL worder_beats: got aw=%0d w=%0d aok=%0d expected 2 2 2",
                            aw_n - aw0, w_n - w0, aok_n - aok0);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] ok_vec = 10'h000;
      logic [9:0] valid_vec = 10'h000;
      int ar0 = ar_n, aw0 = aw_n, w0 = w_n;
      bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h1111_2222;
      bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (c == 0) begin
            bus.mem_addr = 32'h0000_0020; bus.mem_ben = 4'b1111; bus.mem_wr = 1'b0;
         end else if (c == 4) begin
            bus.mem_addr = 32'h0000_0024; bus.mem_wdata = 32'h5555_AAAA; bus.mem_wr = 1'b1;
         end else if (c == 7) begin
            bus.mem_ben = 4'b0000;
         end
         sample();
         ok_vec[c]    = bus.mem_data_ok;
         valid_vec[c] = bus.arvalid || bus.awvalid || bus.wvalid;
      end
      drive_idle();
      checks++;
      if (ok_vec !== 10'h048) begin
         errors++; $display("FAIL b2b_data_ok: got %b expected %b", ok_vec, 10'h048);
      end
      checks++;
      if (valid_vec !== 10'h022) begin
         errors++; $display("FAIL b2b_valids: got %b expected %b", valid_vec, 10'h022);
      end
      checks++;
      if (ar_n - ar0 != 1 || aw_n - aw0 != 1 || w_n - w0 != 1 || bus.mem_rdata !== 32'h1111_2222) begin
         errors++; $display("FAIL b2b_beats: got ar=%0d aw=%0d w=%0d rdata=%h expected 1 1 1 11112222",
                            ar_n - ar0, aw_n - aw0, w_n - w0, bus.mem_rdata);
      end
   endtask

   task automatic test_half_stall();
      tick();
      bus.mem_addr = 32'h1000_0002; bus.mem_ben = 4'b1100; bus.mem_wr = 1'b0;
      sample();
      for (int c = 1; c <= 5; c++) begin
         tick(); sample();
         checks++;
         if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1000_0002 || bus.arsize !== 3'd1 || bus.mem_addr_ok !== 1'b0) begin
            errors++; $display("FAIL stall_c%0d: got v=%b a=%h s=%0d ok=%b expected 1 10000002 1 0",
                               c, bus.arvalid, bus.araddr, bus.arsize, bus.mem_addr_ok);
         end
      end
      tick();
      bus.arready = 1'b1;
      sample();
      checks++;
      if (ctl_vec() !== 7'b1000010) begin
         errors++; $display("FAIL stall_accept: got %b expected %b", ctl_vec(), 7'b1000010);
      end
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1234_0000;
      sample();
      tick();
      bus.rvalid = 1'b0; bus.mem_ben = 4'b0000;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0000001 || bus.mem_rdata !== 32'h1234_0000) begin
         errors++; $display("FAIL stall_data: got %b/%h expected %b/12340000",
                            ctl_vec(), bus.mem_rdata, 7'b0000001);
      end
      tick(); sample();
   endtask

   task automatic test_reset_mid();
      tick();
      bus.mem_addr = 32'h0000_0040; bus.mem_ben = 4'b1111; bus.mem_wr = 1'b0; bus.arready = 1'b1;
      sample();
      tick(); sample();
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_F00D; rst = 1'b1;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0100000) begin
         errors++; $display("FAIL rstmid_rd_data: got %b expected %b", ctl_vec(), 7'b0100000);
      end
      tick();
      rst = 1'b0; bus.rvalid = 1'b0; bus.mem_ben = 4'b0000;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0000000 || bus.mem_rdata !== 32'h0 || bus.araddr !== 32'h0) begin
         errors++; $display("FAIL rstmid_state: got %b/%h/%h expected %b/0/0",
                            ctl_vec(), bus.mem_rdata, bus.araddr, 7'b0000000);
      end
      tick(); sample();
      checks++;
      if (ctl_vec() !== 7'b0000000) begin
         errors++; $display("FAIL rstmid_no_ok: got %b expected %b", ctl_vec(), 7'b0000000);
      end
      tick();
      bus.mem_addr = 32'h0000_0080; bus.mem_ben = 4'b0011; bus.mem_wdata = 32'h0000_BEEF;
      bus.mem_wr = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
      sample();
      tick(); sample();
      checks++;
      if (ctl_vec() !== 7'b0011010 || bus.awsize !== 3'd1 || bus.wstrb !== 4'b0011 || bus.awaddr !== 32'h80) begin
         errors++; $display("FAIL rstmid_new_req: got %b/%0d/%b/%h expected %b/1/0011/00000080",
                            ctl_vec(), bus.awsize, bus.wstrb, bus.awaddr, 7'b0011010);
      end
      tick();
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1;
      sample();
      checks++;
      if (ctl_vec() !== 7'b0000101) begin
         errors++; $display("FAIL rstmid_resp: got %b expected %b", ctl_vec(), 7'b0000101);
      end
      tick();
      bus.bvalid = 1'b0; bus.mem_ben = 4'b0000;
      sample();
      tick(); sample();
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_byte_write();
      test_write_order();
      test_back_to_back();
      test_half_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
